// File: rtl/hc595_serial_driver.sv
// hc595_serial_driver
// Serializes one parallel frame onto DS. It generates SHCP pulses for the
// shift stage of a 74HC595 and then issues a single STCP latch pulse.
// Every downstream-facing pin comes directly from a flop, so the pins carry
// glitch-free levels.
module hc595_serial_driver #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              DS,
    output logic              SHCP,
    output logic              STCP,
    output logic              OE,
    output logic              busy,
    output logic              done
);

    // The divider needs at least one bit, even when CLK_DIV is 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [BIT_W-1:0]  bits_r, bits_s;
    logic              div_last_s;
    logic              ds_r, ds_s;
    logic              shcp_r, shcp_s;
    logic              stcp_r, stcp_s;
    logic              oe_r, oe_s;
    logic              done_r, done_s;

    // Returns the bit that goes out next. The shift register always presents
    // the next bit at the same end.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        if (MSB_FIRST != 0) begin
            return v[DATA_W-1];
        end else begin
            return v[0];
        end
    endfunction

    // Moves the frame one position toward the output end.
    function automatic logic [DATA_W-1:0] shift_frame(input logic [DATA_W-1:0] v);
        if (MSB_FIRST != 0) begin
            return v << 1;
        end else begin
            return v >> 1;
        end
    endfunction

    // Next-state and next-output logic for the serializer FSM.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        div_s      = div_r;
        bits_s     = bits_r;
        ds_s       = ds_r;
        shcp_s     = shcp_r;
        stcp_s     = stcp_r;
        oe_s       = oe_r;
        done_s     = 1'b0;
        shifted_s  = shift_frame(shreg_r);
        div_last_s = (div_r == DIV_LAST);

        case (state_r)
            ST_IDLE: begin
                shcp_s = 1'b0;
                stcp_s = 1'b0;
                div_s  = '0;
                if (din_valid) begin
                    // The frame is captured here, so later changes on din are ignored.
                    state_s = ST_SETUP;
                    shreg_s = din;
                    ds_s    = first_bit(din);
                    bits_s  = BIT_FULL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_last_s) begin
                    div_s   = '0;
                    shcp_s  = 1'b1;
                    state_s = ST_HIGH;
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            ST_HIGH: begin
                if (div_last_s) begin
                    div_s  = '0;
                    shcp_s = 1'b0;
                    if (bits_r <= BIT_ONE) begin
                        // The last bit has been clocked out, so start the latch pulse.
                        bits_s  = '0;
                        stcp_s  = 1'b1;
                        state_s = ST_LATCH;
                    end else begin
                        // DS only moves on the edge where SHCP falls. This gives
                        // full setup and hold time around each SHCP rise.
                        bits_s  = bits_r - 1'b1;
                        shreg_s = shifted_s;
                        ds_s    = first_bit(shifted_s);
                        state_s = ST_SETUP;
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            ST_LATCH: begin
                if (div_last_s) begin
                    div_s   = '0;
                    stcp_s  = 1'b0;
                    done_s  = 1'b1;
                    // Outputs are enabled once real data has been latched.
                    oe_s    = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                shcp_s  = 1'b0;
                stcp_s  = 1'b0;
                div_s   = '0;
            end
        endcase
    end

    // State and output registers. Reset is synchronous, and an aborted frame
    // never issues a latch pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            div_r   <= '0;
            bits_r  <= '0;
            ds_r    <= 1'b0;
            shcp_r  <= 1'b0;
            stcp_r  <= 1'b0;
            oe_r    <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            div_r   <= div_s;
            bits_r  <= bits_s;
            ds_r    <= ds_s;
            shcp_r  <= shcp_s;
            stcp_r  <= stcp_s;
            oe_r    <= oe_s;
            done_r  <= done_s;
        end
    end

    assign din_ready = rst && (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign DS        = ds_r;
    assign SHCP      = shcp_r;
    assign STCP      = stcp_r;
    assign OE        = oe_r;
    assign done      = done_r;

endmodule

// File: tb/tb_hc595_serial_driver.sv
// Directed bench for hc595_serial_driver. It uses three instances:
// the default configuration, an LSB-first variant, and a 4-bit frame with
// CLK_DIV=1. A 74HC595 model sits on each instance.
module tb_hc595_serial_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] valid_v = 3'b000;
    int         sel = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    logic ready0, ds0, shcp0, stcp0, oe0, busy0, done0;
    logic ready1, ds1, shcp1, stcp1, oe1, busy1, done1;
    logic ready2, ds2, shcp2, stcp2, oe2, busy2, done2;
    logic m_ready, m_ds, m_shcp, m_stcp, m_oe, m_busy, m_done;

    hc595_serial_driver #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_v[0]), .din_ready(ready0),
        .DS(ds0), .SHCP(shcp0), .STCP(stcp0), .OE(oe0), .busy(busy0), .done(done0));

    hc595_serial_driver #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_v[1]), .din_ready(ready1),
        .DS(ds1), .SHCP(shcp1), .STCP(stcp1), .OE(oe1), .busy(busy1), .done(done1));

    hc595_serial_driver #(.DATA_W(4), .CLK_DIV(1), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .rst(rst), .din(din[3:0]), .din_valid(valid_v[2]), .din_ready(ready2),
        .DS(ds2), .SHCP(shcp2), .STCP(stcp2), .OE(oe2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    // Route the selected instance to the shared frame monitor.
    always_comb begin
        case (sel)
            1: {m_ready, m_ds, m_shcp, m_stcp, m_oe, m_busy, m_done} =
                {ready1, ds1, shcp1, stcp1, oe1, busy1, done1};
            2: {m_ready, m_ds, m_shcp, m_stcp, m_oe, m_busy, m_done} =
                {ready2, ds2, shcp2, stcp2, oe2, busy2, done2};
            default: {m_ready, m_ds, m_shcp, m_stcp, m_oe, m_busy, m_done} =
                {ready0, ds0, shcp0, stcp0, oe0, busy0, done0};
        endcase
    end

    // Downstream 74HC595 models. The LSB-first instance is wired reversed,
    // so its model reconstructs the frame in natural bit order.
    logic [7:0] m0_sr = 8'h00, m0_q = 8'h00;
    logic [7:0] m1_sr = 8'h00, m1_q = 8'h00;
    logic [3:0] m2_sr = 4'h0,  m2_q = 4'h0;
    int  stcp0_cnt = 0;
    time stcp0_last_t = 0, stcp0_prev_t = 0;

    always @(posedge shcp0) m0_sr <= {m0_sr[6:0], ds0};
    always @(posedge stcp0) begin
        m0_q         <= m0_sr;
        stcp0_cnt    <= stcp0_cnt + 1;
        stcp0_prev_t <= stcp0_last_t;
        stcp0_last_t <= $time;
    end
    always @(posedge shcp1) m1_sr <= {ds1, m1_sr[7:1]};
    always @(posedge stcp1) m1_q  <= m1_sr;
    always @(posedge shcp2) m2_sr <= {m2_sr[2:0], ds2};
    always @(posedge stcp2) m2_q  <= m2_sr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call this at a negedge, with valid already raised for the selected
    // instance. The first posedge is the accept edge E0. Sample cycle c is
    // the cycle E0+c.
    task automatic run_frame(input string tag, input int nb, input int cd,
                             input logic [7:0] exp_seq, input logic oe_before,
                             input bit hold_valid, input logic [7:0] next_din,
                             input bit mangle);
        int total;
        int rises, first_rise, stcp_hi, first_stcp, done_cnt, done_at;
        int ready_early, busy_miss, ds_viol;
        logic [7:0] seq;
        logic prev_shcp, prev_ds, oe_pre, oe_end, ready_end;
        total = (2*nb + 1)*cd + 1;
        rises = 0; first_rise = -1; stcp_hi = 0; first_stcp = -1;
        done_cnt = 0; done_at = -1; ready_early = 0; busy_miss = 0; ds_viol = 0;
        seq = 8'h00; prev_shcp = m_shcp; prev_ds = m_ds;
        oe_pre = 1'bx; oe_end = 1'bx; ready_end = 1'bx;
        for (int c = 1; c <= total; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_shcp && !prev_shcp) begin
                if (rises < 8) seq[rises] = m_ds;
                if (first_rise < 0) first_rise = c;
                rises++;
            end
            if (m_shcp && prev_shcp && (m_ds !== prev_ds)) ds_viol++;
            if (m_stcp) begin
                stcp_hi++;
                if (first_stcp < 0) first_stcp = c;
            end
            if (m_done) begin
                done_cnt++;
                done_at = c;
            end
            if (c < total && m_ready) ready_early++;
            if (c < total && !m_busy) busy_miss++;
            if (c == total - 1) oe_pre = m_oe;
            if (c == total) begin
                oe_end = m_oe;
                ready_end = m_ready;
            end
            prev_shcp = m_shcp;
            prev_ds = m_ds;
            if (c == 1) begin
                din = next_din;
                if (!hold_valid) valid_v[sel] = 1'b0;
            end
            if (mangle) begin
                din = 8'($urandom);
                valid_v[sel] = (c < total - 4) ? ~valid_v[sel] : 1'b0;
            end
        end
        check($sformatf("%s.shcp_rises", tag), rises, nb);
        check($sformatf("%s.ds_seq", tag), seq, exp_seq);
        check($sformatf("%s.first_shcp", tag), first_rise, cd + 1);
        check($sformatf("%s.stcp_width", tag), stcp_hi, cd);
        check($sformatf("%s.stcp_start", tag), first_stcp, 2*nb*cd + 1);
        check($sformatf("%s.done_count", tag), done_cnt, 1);
        check($sformatf("%s.done_cycle", tag), done_at, total);
        check($sformatf("%s.oe_before", tag), oe_pre, oe_before);
        check($sformatf("%s.oe_after", tag), oe_end, 1'b0);
        check($sformatf("%s.ready_at_done", tag), ready_end, 1'b1);
        check($sformatf("%s.ready_early", tag), ready_early, 0);
        check($sformatf("%s.busy_gap", tag), busy_miss, 0);
        check($sformatf("%s.ds_stable_hi", tag), ds_viol, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        // Reset state
        sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ds", m_ds, 1'b0);
        check("rst.shcp", m_shcp, 1'b0);
        check("rst.stcp", m_stcp, 1'b0);
        check("rst.oe", m_oe, 1'b1);
        check("rst.busy", m_busy, 1'b0);
        check("rst.done", m_done, 1'b0);
        check("rst.ready", m_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("idle.ready", m_ready, 1'b1);

        // 0xA5, MSB first: 1,0,1,0,0,1,0,1
        din = 8'hA5; valid_v[0] = 1'b1;
        run_frame("a5", 8, 4, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
        check("a5.latched", m0_q, 8'hA5);
        repeat (3) @(negedge clk);
        check("a5.ds_hold", m_ds, 1'b1);
        check("a5.idle_busy", m_busy, 1'b0);

        // 0x96 with din and din_valid disturbed mid-frame: 1,0,0,1,0,1,1,0
        din = 8'h96; valid_v[0] = 1'b1;
        run_frame("mangle", 8, 4, 8'h69, 1'b0, 1'b0, 8'h00, 1'b1);
        check("mangle.latched", m0_q, 8'h96);

        // Back-to-back 0x3C then 0xC3, with valid held high
        @(negedge clk);
        din = 8'h3C; valid_v[0] = 1'b1;
        run_frame("b2b1", 8, 4, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0);
        check("b2b1.latched", m0_q, 8'h3C);
        run_frame("b2b2", 8, 4, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0);
        check("b2b2.latched", m0_q, 8'hC3);
        check("b2b.stcp_spacing", 32'(stcp0_last_t - stcp0_prev_t), 32'd690);

        // Reset during the 5th HIGH of frame 0x5A (cycles 37..40)
        @(negedge clk);
        din = 8'h5A; valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (37) @(negedge clk);
        check("abort.in_high", m_shcp, 1'b1);
        check("abort.ds_before", m_ds, 1'b1);
        n_before = stcp0_cnt;
        rst = 1'b0;
        @(negedge clk);
        check("abort.shcp", m_shcp, 1'b0);
        check("abort.stcp", m_stcp, 1'b0);
        check("abort.ds", m_ds, 1'b0);
        check("abort.oe", m_oe, 1'b1);
        check("abort.busy", m_busy, 1'b0);
        check("abort.ready", m_ready, 1'b0);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("abort.no_stcp", stcp0_cnt, n_before);
        check("abort.latch_kept", m0_q, 8'hC3);

        // LSB first, 0x01: 1,0,0,0,0,0,0,0
        sel = 1;
        @(negedge clk);
        din = 8'h01; valid_v[1] = 1'b1;
        run_frame("lsb01", 8, 4, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0);
        check("lsb01.latched", m1_q, 8'h01);

        // DATA_W=4, CLK_DIV=1, 0xB: 1,0,1,1 and done at E0+10
        sel = 2;
        @(negedge clk);
        din = 8'h0B; valid_v[2] = 1'b1;
        run_frame("small", 4, 1, 8'h0D, 1'b1, 1'b0, 8'h0B, 1'b0);
        check("small.latched", m2_q, 4'hB);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
